// File: rtl/dff_mem_pkg.sv
// Shared types and constants for the DFF-RAM arbiter slice.
package dff_mem_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Address width for a given RAM size; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned bytes);
    return (bytes <= 2) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/dff_mem_arbiter_if.sv
// Request/grant/data bundle between the two requesters and the DFF-RAM arbiter.
interface dff_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 4
);
  import dff_mem_pkg::*;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] we;
  logic [NUM_PORTS-1:0] lock;
  logic [ADDR_W-1:0]    addr0;
  logic [ADDR_W-1:0]    addr1;
  logic [DATA_W-1:0]    wdata0;
  logic [DATA_W-1:0]    wdata1;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] ack;
  logic [DATA_W-1:0]    rdata;
  logic                 busy;

  modport master (
    output req, we, lock, addr0, addr1, wdata0, wdata1,
    input  gnt, ack, rdata, busy
  );

  modport slave (
    input  req, we, lock, addr0, addr1, wdata0, wdata1,
    output gnt, ack, rdata, busy
  );

endinterface

// File: rtl/dff_mem_core.sv
// Single-port byte-wide register-array RAM with registered read and out-of-range guard.
module dff_mem_core import dff_mem_pkg::*; #(
  parameter int unsigned RAM_BYTES = 16,
  parameter int unsigned ADDR_W    = addr_w(RAM_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [RAM_BYTES];
  logic              in_range;

  // Only matters for non-power-of-2 sizes, where the address can exceed the array.
  assign in_range = (32'(addr) < RAM_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_BYTES; i++) begin
        mem_q[i] <= '0;
      end
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        if (in_range) begin
          mem_q[addr] <= wdata;
        end
        rdata <= wdata;
      end else begin
        rdata <= in_range ? mem_q[addr] : '0;
      end
    end
  end

endmodule

// File: rtl/dff_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a DFF RAM (IDLE -> ACCESS -> DONE).
// Optional grant locking is enabled by defining DFF_ARB_LOCK_EN.
module dff_mem_arbiter import dff_mem_pkg::*; #(
  parameter int unsigned RAM_BYTES = 16
) (
  input logic              clk,
  input logic              rst,
  dff_mem_arbiter_if.slave bus
);

  localparam int unsigned ADDR_W = addr_w(RAM_BYTES);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic                   last_q, last_d;
  logic                   win_q, win_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   pick;
  logic [DATA_W-1:0]      core_rdata;

`ifdef DFF_ARB_LOCK_EN
  logic lock_vld_q, lock_vld_d;
  logic lock_own_q, lock_own_d;
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  // Winner among requesters in IDLE: a held lock first, else the port not served last.
  always_comb begin
    pick = (bus.req == 2'b11) ? ~last_q : bus.req[1];
`ifdef DFF_ARB_LOCK_EN
    if (lock_vld_q && bus.req[lock_own_q]) begin
      pick = lock_own_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef DFF_ARB_LOCK_EN
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef DFF_ARB_LOCK_EN
        if (lock_vld_q && !bus.req[lock_own_q]) begin
          lock_vld_d = 1'b0;
        end
`endif
        if (|bus.req) begin
          win_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          we_d    = bus.we[pick];
          addr_d  = pick ? bus.addr1 : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ack_d   = win_q ? 2'b10 : 2'b01;
        state_d = DONE;
      end
      DONE: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
`ifdef DFF_ARB_LOCK_EN
        // The round-robin pointer is frozen for as long as the lock is held.
        if (bus.lock[win_q]) begin
          lock_vld_d = 1'b1;
          lock_own_d = win_q;
        end else begin
          lock_vld_d = 1'b0;
          last_d     = win_q;
        end
`else
        last_d = win_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DFF_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  dff_mem_core #(
    .RAM_BYTES (RAM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == ACCESS),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (core_rdata)
  );

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = core_rdata;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Self-checking bench: directed vector table, reset/out-of-range sequences, random vs. model.
module tb_dff_mem_arbiter;
  import dff_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_mem_arbiter_if #(.ADDR_W(4)) bus16 ();
  dff_mem_arbiter_if #(.ADDR_W(4)) bus12 ();

  dff_mem_arbiter #(.RAM_BYTES(16)) dut (.clk(clk), .rst(rst), .bus(bus16));
  dff_mem_arbiter #(.RAM_BYTES(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] req, we, lk;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[11];

  // Reference model state
  logic [7:0] mem [16];
  int         last;
  bit         lk_vld;
  int         lk_own;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus16.req = '0;
    bus12.req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst gnt", 32'(bus16.gnt), 0);
    chk("rst ack", 32'(bus16.ack), 0);
    chk("rst rdata", 32'(bus16.rdata), 0);
    chk("rst busy", 32'(bus16.busy), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [1:0] req, input logic [1:0] we,
                     input logic [1:0] lk, input logic [3:0] a0, input logic [3:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, input bit scramble,
                     input logic [1:0] exp_gnt, input logic [7:0] exp_rdata);
    @(negedge clk);
    bus16.req = req; bus16.we = we; bus16.lock = lk;
    bus16.addr0 = a0; bus16.addr1 = a1; bus16.wdata0 = d0; bus16.wdata1 = d1;
    @(posedge clk); #1;
    chk({tag, " access gnt"}, 32'(bus16.gnt), 32'(exp_gnt));
    chk({tag, " access busy"}, 32'(bus16.busy), 1);
    chk({tag, " access ack"}, 32'(bus16.ack), 0);
    if (scramble) begin
      @(negedge clk);
      bus16.req = 2'($urandom); bus16.we = 2'($urandom);
      bus16.addr0 = 4'($urandom); bus16.addr1 = 4'($urandom);
      bus16.wdata0 = 8'($urandom); bus16.wdata1 = 8'($urandom);
    end
    @(posedge clk); #1;
    chk({tag, " done ack"}, 32'(bus16.ack), 32'(exp_gnt));
    chk({tag, " done rdata"}, 32'(bus16.rdata), 32'(exp_rdata));
    @(negedge clk);
    bus16.req = '0;
    @(posedge clk); #1;
    chk({tag, " idle gnt"}, 32'(bus16.gnt), 0);
    chk({tag, " idle ack"}, 32'(bus16.ack), 0);
    chk({tag, " idle busy"}, 32'(bus16.busy), 0);
    chk({tag, " held rdata"}, 32'(bus16.rdata), 32'(exp_rdata));
  endtask

  task automatic txn12(input string tag, input logic we, input logic [3:0] a,
                       input logic [7:0] d, input bit chk_data, input logic [7:0] exp_rdata);
    @(negedge clk);
    bus12.req = 2'b01; bus12.we = {1'b0, we}; bus12.addr0 = a; bus12.wdata0 = d;
    @(posedge clk); #1;
    chk({tag, " gnt"}, 32'(bus12.gnt), 1);
    @(posedge clk); #1;
    chk({tag, " ack"}, 32'(bus12.ack), 1);
    if (chk_data) chk({tag, " rdata"}, 32'(bus12.rdata), 32'(exp_rdata));
    @(negedge clk);
    bus12.req = '0;
    @(posedge clk);
  endtask

  initial begin
    bus16.req = '0; bus16.we = '0; bus16.lock = '0;
    bus16.addr0 = '0; bus16.addr1 = '0; bus16.wdata0 = '0; bus16.wdata1 = '0;
    bus12.req = '0; bus12.we = '0; bus12.lock = '0;
    bus12.addr0 = '0; bus12.addr1 = '0; bus12.wdata0 = '0; bus12.wdata1 = '0;

    tbl[0]  = '{2'b01, 2'b00, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 8'h00};
    tbl[1]  = '{2'b01, 2'b01, 2'b00, 4'd5, 4'd0, 8'hA5, 8'h00, 2'b01, 8'hA5};
    tbl[2]  = '{2'b10, 2'b00, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00, 2'b10, 8'hA5};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd3, 8'h00, 8'h00, 2'b01, 8'hA5};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd3, 8'h00, 8'h00, 2'b10, 8'h00};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd3, 8'h00, 8'h00, 2'b01, 8'hA5};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd3, 8'h00, 8'h00, 2'b10, 8'h00};
    tbl[7]  = '{2'b11, 2'b00, 2'b01, 4'd5, 4'd3, 8'h00, 8'h00, 2'b01, 8'hA5};
`ifdef DFF_ARB_LOCK_EN
    tbl[8]  = '{2'b11, 2'b00, 2'b01, 4'd5, 4'd3, 8'h00, 8'h00, 2'b01, 8'hA5};
`else
    tbl[8]  = '{2'b11, 2'b00, 2'b01, 4'd5, 4'd3, 8'h00, 8'h00, 2'b10, 8'h00};
`endif
    tbl[9]  = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd3, 8'h00, 8'h00, 2'b01, 8'hA5};
    tbl[10] = '{2'b11, 2'b00, 2'b00, 4'd5, 4'd3, 8'h00, 8'h00, 2'b10, 8'h00};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].we, tbl[i].lk, tbl[i].a0, tbl[i].a1,
          tbl[i].d0, tbl[i].d1, 1'b0, tbl[i].gnt, tbl[i].rdata);
    end

    // Reset in the middle of a write: the access and its ack are dropped.
    @(negedge clk);
    bus16.req = 2'b01; bus16.we = 2'b01; bus16.addr0 = 4'd7; bus16.wdata0 = 8'h3C;
    @(posedge clk); #1;
    chk("midrst access gnt", 32'(bus16.gnt), 1);
    @(negedge clk);
    rst = 1'b1;
    bus16.req = '0;
    #1;
    chk("midrst gnt", 32'(bus16.gnt), 0);
    chk("midrst busy", 32'(bus16.busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst ack", 32'(bus16.ack), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    txn("midrst readback", 2'b01, 2'b00, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, 1'b0, 2'b01, 8'h00);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    last = 1; lk_vld = 0; lk_own = 0;
    for (int n = 0; n < 200; n++) begin
      logic [1:0] r, wv, lk;
      logic [3:0] a0, a1, a;
      logic [7:0] d0, d1, d, exp;
      int w;
      r = 2'($urandom); wv = 2'($urandom); lk = 2'($urandom);
      a0 = 4'($urandom); a1 = 4'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
      if (r == 2'b00) begin
        @(negedge clk);
        bus16.req = '0; bus16.lock = lk;
        @(posedge clk); #1;
        chk("rand idle busy", 32'(bus16.busy), 0);
        chk("rand idle gnt", 32'(bus16.gnt), 0);
        lk_vld = 0;
      end else begin
        if (lk_vld && r[lk_own]) begin
          w = lk_own;
        end else begin
          lk_vld = 0;
          if (r == 2'b11) w = 1 - last;
          else w = r[1] ? 1 : 0;
        end
        a = (w == 1) ? a1 : a0;
        d = (w == 1) ? d1 : d0;
        if (wv[w]) begin
          mem[a] = d;
          exp = d;
        end else begin
          exp = mem[a];
        end
`ifdef DFF_ARB_LOCK_EN
        if (lk[w]) begin
          lk_vld = 1;
          lk_own = w;
        end else begin
          lk_vld = 0;
          last = w;
        end
`else
        last = w;
`endif
        txn($sformatf("rand%0d", n), r, wv, lk, a0, a1, d0, d1, 1'b1,
            (w == 1) ? 2'b10 : 2'b01, exp);
      end
    end

    // Non-power-of-2 RAM: out-of-range accesses still ack, never alias.
    txn12("oor wr13", 1'b1, 4'd13, 8'hFF, 1'b0, 8'h00);
    txn12("oor rd13", 1'b0, 4'd13, 8'h00, 1'b1, 8'h00);
    txn12("oor rd5", 1'b0, 4'd5, 8'h00, 1'b1, 8'h00);
    txn12("wr11", 1'b1, 4'd11, 8'h5A, 1'b1, 8'h5A);
    txn12("rd11", 1'b0, 4'd11, 8'h00, 1'b1, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
